// File: rtl/uninasoc_pkg.sv
// uninasoc_pkg: SoC-wide constants, including irq_ctrl register offsets and ID type
package uninasoc_pkg;
  localparam int NUM_IRQ = 3;
  localparam int IRQ_CTRL_PENDING_OFF  = 'h00;
  localparam int IRQ_CTRL_ENABLE_OFF   = 'h04;
  localparam int IRQ_CTRL_MODE_OFF     = 'h08;
  localparam int IRQ_CTRL_CLAIM_OFF    = 'h0C;
  localparam int IRQ_CTRL_COMPLETE_OFF = 'h10;
  localparam int IRQ_CTRL_INSERV_OFF   = 'h14;
  typedef logic [4:0] irq_id_t;
endpackage

// File: rtl/irq_sync.sv
// irq_sync: N-stage resettable synchroniser, wire-through when N = 0
module irq_sync #(
  parameter int W = 1,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  if (N == 0) begin : g_bypass
    assign o_q = i_d;
  end else begin : g_chain
    logic [W-1:0] r_stage [N];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < N; j++) r_stage[j] <= '0;
      end else begin
        r_stage[0] <= i_d;
        for (int j = 1; j < N; j++) r_stage[j] <= r_stage[j-1];
      end
    end
    assign o_q = r_stage[N-1];
  end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: per-source enable/mode/pending with lowest-index claim/complete,
// single-cycle register port and a registered core interrupt.
module irq_ctrl
  import uninasoc_pkg::*;
#(
  parameter int NUM_SRC     = NUM_IRQ,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 5
) (
  input  logic               sys_clock_i,
  input  logic               sys_reset_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               reg_req_i,
  input  logic               reg_we_i,
  input  logic [ADDR_W-1:0]  reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  output logic               reg_ready_o,
  output logic               irq_o
);
  localparam int WW = ADDR_W - 2;
  logic [NUM_SRC-1:0] w_sync, r_prev, r_pending, r_enable, r_mode, r_inserv;
  logic [NUM_SRC-1:0] w_rise, w_elig, w_claim_set, w_cmp_clr, w_pend_clr, w_pend_nxt;
  logic [WW-1:0] w_word;
  logic w_rd, w_wr, w_claim, w_unused;
  logic w_sel_pend, w_sel_en, w_sel_mode, w_sel_claim, w_sel_cmp, w_sel_ins;
  irq_id_t w_id;
  logic [31:0] w_rdata;

  irq_sync #(.W(NUM_SRC), .N(SYNC_STAGES)) u_sync (
    .clk(sys_clock_i),
    .rst(sys_reset_i),
    .i_d(irq_src_i),
    .o_q(w_sync)
  );

  assign w_unused    = ^reg_addr_i[1:0];
  assign w_word      = reg_addr_i[ADDR_W-1:2];
  assign w_rd        = reg_req_i & ~reg_we_i;
  assign w_wr        = reg_req_i & reg_we_i;
  assign w_sel_pend  = w_word == WW'(IRQ_CTRL_PENDING_OFF >> 2);
  assign w_sel_en    = w_word == WW'(IRQ_CTRL_ENABLE_OFF >> 2);
  assign w_sel_mode  = w_word == WW'(IRQ_CTRL_MODE_OFF >> 2);
  assign w_sel_claim = w_word == WW'(IRQ_CTRL_CLAIM_OFF >> 2);
  assign w_sel_cmp   = w_word == WW'(IRQ_CTRL_COMPLETE_OFF >> 2);
  assign w_sel_ins   = w_word == WW'(IRQ_CTRL_INSERV_OFF >> 2);

  assign w_rise = w_sync & ~r_prev;
  assign w_elig = r_pending & r_enable & ~r_inserv;

  always_comb begin
    w_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (w_elig[i]) w_id = irq_id_t'(i + 1);
  end

  assign w_claim = w_rd & w_sel_claim & (w_id != '0);

  always_comb begin
    w_claim_set = '0;
    w_cmp_clr   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_claim_set[i] = w_claim && w_id == irq_id_t'(i + 1);
      w_cmp_clr[i]   = w_wr && w_sel_cmp && reg_wdata_i == 32'(i + 1);
    end
  end

  // a fresh edge outranks W1C/claim so it is never lost; level bits just track the line
  assign w_pend_clr = (w_wr & w_sel_pend ? reg_wdata_i[NUM_SRC-1:0] : '0) | w_claim_set;
  assign w_pend_nxt = (r_mode & ((r_pending & ~w_pend_clr) | w_rise)) | (~r_mode & w_sync);

  assign w_rdata = w_sel_pend  ? 32'(r_pending) :
                   w_sel_en    ? 32'(r_enable)  :
                   w_sel_mode  ? 32'(r_mode)    :
                   w_sel_claim ? 32'(w_id)      :
                   w_sel_ins   ? 32'(r_inserv)  : '0;

  always_ff @(posedge sys_clock_i) begin
    if (sys_reset_i) begin
      r_prev      <= '0;
      r_pending   <= '0;
      r_enable    <= '0;
      r_mode      <= '0;
      r_inserv    <= '0;
      irq_o       <= 1'b0;
      reg_ready_o <= 1'b0;
      reg_rdata_o <= '0;
    end else begin
      r_prev      <= w_sync;
      r_pending   <= w_pend_nxt;
      r_enable    <= w_wr & w_sel_en ? reg_wdata_i[NUM_SRC-1:0] : r_enable;
      r_mode      <= w_wr & w_sel_mode ? reg_wdata_i[NUM_SRC-1:0] : r_mode;
      r_inserv    <= (r_inserv | w_claim_set) & ~w_cmp_clr;
      irq_o       <= |w_elig;
      reg_ready_o <= reg_req_i;
      reg_rdata_o <= w_rd ? w_rdata : '0;
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus random traffic against a cycle-level
// behavioural model of the controller (NUM_SRC=3, SYNC_STAGES=2).
module tb_irq_ctrl;
  localparam int NS = 3;
  localparam int SS = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NS-1:0] src = '0;
  logic req = 1'b0, we = 1'b0;
  logic [4:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic ready, irq;
  int n_chk = 0, n_pass = 0;

  logic [NS-1:0] m_pend = '0, m_en = '0, m_mode = '0, m_ins = '0;
  logic [NS-1:0] hist[$] = '{3'b0, 3'b0, 3'b0};
  logic m_irq = 1'b0, m_rdy = 1'b0;
  logic [31:0] m_rdata = '0;

  irq_ctrl #(.NUM_SRC(NS), .SYNC_STAGES(SS), .ADDR_W(5)) dut (
    .sys_clock_i(clk),
    .sys_reset_i(rst),
    .irq_src_i(src),
    .reg_req_i(req),
    .reg_we_i(we),
    .reg_addr_i(addr),
    .reg_wdata_i(wdata),
    .reg_rdata_o(rdata),
    .reg_ready_o(ready),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // model computes what every output/register must be after the coming edge
  task automatic cycle();
    logic [NS-1:0] s, p, np, ni, ne, nm;
    logic [31:0] rv;
    logic nirq, claim;
    int id;
    if (rst) begin
      np = '0; ni = '0; ne = '0; nm = '0; nirq = 0; rv = '0;
      hist.push_back('0);
      @(posedge clk);
      #1;
      m_pend = np; m_ins = ni; m_en = ne; m_mode = nm; m_irq = 0; m_rdy = 0; m_rdata = '0;
    end else begin
      s = hist[hist.size()-SS];
      p = hist[hist.size()-SS-1];
      id = 0;
      for (int i = NS - 1; i >= 0; i--) if (m_pend[i] && m_en[i] && !m_ins[i]) id = i + 1;
      nirq = id != 0;
      case (addr[4:2])
        3'd0: rv = 32'(m_pend);
        3'd1: rv = 32'(m_en);
        3'd2: rv = 32'(m_mode);
        3'd3: rv = 32'(id);
        3'd5: rv = 32'(m_ins);
        default: rv = '0;
      endcase
      claim = req && !we && addr[4:2] == 3'd3 && id != 0;
      np = m_pend; ni = m_ins; ne = m_en; nm = m_mode;
      for (int i = 0; i < NS; i++) begin
        if (m_mode[i]) begin
          if (req && we && addr[4:2] == 3'd0 && wdata[i]) np[i] = 0;
          if (claim && id == i + 1) np[i] = 0;
          if (s[i] && !p[i]) np[i] = 1;
        end else np[i] = s[i];
        if (claim && id == i + 1) ni[i] = 1;
        if (req && we && addr[4:2] == 3'd4 && wdata == 32'(i + 1)) ni[i] = 0;
      end
      if (req && we && addr[4:2] == 3'd1) ne = wdata[NS-1:0];
      if (req && we && addr[4:2] == 3'd2) nm = wdata[NS-1:0];
      hist.push_back(src);
      @(posedge clk);
      #1;
      m_pend = np; m_ins = ni; m_en = ne; m_mode = nm; m_irq = nirq;
      m_rdy = req; m_rdata = (req && !we) ? rv : '0;
    end
    void'(hist.pop_front());
    chk("irq_o", 32'(irq), 32'(m_irq));
    chk("ready", 32'(ready), 32'(m_rdy));
    chk("rdata", rdata, m_rdata);
  endtask

  task automatic reg_wr(input logic [4:0] a, input logic [31:0] d);
    req = 1; we = 1; addr = a; wdata = d;
    cycle();
    req = 0; we = 0; wdata = '0;
  endtask

  task automatic reg_rd(input logic [4:0] a, output logic [31:0] d);
    req = 1; we = 0; addr = a;
    cycle();
    d = rdata;
    req = 0;
  endtask

  initial begin
    logic [31:0] d;
    // 1: reset, enable+edge mode, single pulse latency
    cycle();
    cycle();
    chk("rst_irq", 32'(irq), 0);
    chk("rst_rdy", 32'(ready), 0);
    chk("rst_rdata", rdata, 0);
    rst = 0;
    reg_wr(5'h04, 7);
    reg_wr(5'h08, 7);
    src = 3'b010;
    cycle();
    src = 0;
    cycle();
    cycle();
    chk("t1_irq_k2", 32'(irq), 0);
    reg_rd(5'h00, d);
    chk("t1_pending", d, 32'h2);
    chk("t1_irq_k3", 32'(irq), 1);
    // 2: claim / complete
    reg_rd(5'h0C, d);
    chk("t2_claim", d, 2);
    reg_rd(5'h00, d);
    chk("t2_pending", d, 0);
    chk("t2_irq", 32'(irq), 0);
    reg_rd(5'h14, d);
    chk("t2_inserv", d, 2);
    reg_wr(5'h10, 2);
    reg_rd(5'h14, d);
    chk("t2_inserv_done", d, 0);
    // 3: two simultaneous edges claimed in priority order
    src = 3'b101;
    cycle();
    src = 0;
    cycle();
    cycle();
    reg_rd(5'h0C, d);
    chk("t3_claim1", d, 1);
    reg_rd(5'h0C, d);
    chk("t3_claim3", d, 3);
    reg_rd(5'h0C, d);
    chk("t3_claim0", d, 0);
    chk("t3_irq", 32'(irq), 0);
    reg_wr(5'h10, 1);
    reg_wr(5'h10, 3);
    // 4: level mode re-asserts after complete while line held
    reg_wr(5'h08, 0);
    src = 3'b100;
    cycle();
    cycle();
    cycle();
    reg_rd(5'h0C, d);
    chk("t4_claim", d, 3);
    reg_wr(5'h10, 3);
    chk("t4_irq_lo", 32'(irq), 0);
    cycle();
    chk("t4_irq_hi", 32'(irq), 1);
    src = 0;
    repeat (4) cycle();
    reg_wr(5'h08, 7);
    // 5: edge collides with W1C; masking keeps pending
    src = 3'b001;
    cycle();
    src = 0;
    cycle();
    src = 3'b001;
    cycle();
    src = 0;
    cycle();
    reg_wr(5'h00, 1);
    reg_rd(5'h00, d);
    chk("t5_pend_kept", d, 1);
    reg_wr(5'h04, 0);
    cycle();
    chk("t5_irq_masked", 32'(irq), 0);
    reg_rd(5'h00, d);
    chk("t5_pend_masked", d, 1);
    reg_wr(5'h00, 1);
    reg_wr(5'h04, 7);
    // 6: ignored completes, unmapped address, reset mid-claim
    reg_wr(5'h10, 7);
    chk("t6_rdy_a", 32'(ready), 1);
    reg_wr(5'h1C, 5);
    chk("t6_rdy_b", 32'(ready), 1);
    reg_wr(5'h10, 9);
    chk("t6_rdy_c", 32'(ready), 1);
    reg_rd(5'h1C, d);
    chk("t6_unmapped", d, 0);
    reg_rd(5'h14, d);
    chk("t6_inserv", d, 0);
    src = 3'b010;
    cycle();
    src = 0;
    cycle();
    cycle();
    reg_rd(5'h0C, d);
    chk("t6_claim", d, 2);
    rst = 1;
    cycle();
    chk("t6_rst_irq", 32'(irq), 0);
    chk("t6_rst_rdy", 32'(ready), 0);
    rst = 0;
    reg_rd(5'h14, d);
    chk("t6_rst_inserv", d, 0);
    reg_rd(5'h04, d);
    chk("t6_rst_enable", d, 0);
    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst = $urandom_range(0, 199) == 0;
      src = NS'($urandom);
      req = $urandom_range(0, 1) == 1;
      we = $urandom_range(0, 2) == 0;
      addr = 5'($urandom_range(0, 7) << 2) | 5'($urandom_range(0, 3));
      wdata = (addr[4:2] == 3'd4) ? 32'($urandom_range(0, 4)) : 32'($urandom);
      cycle();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
